pipe_chain: RTL
===============

Name: pipe_chain

Overview:
- Parametrised, elastic pipeline register chain. Successor to the single-stage stall/flush pipe register.
- Provides DEPTH stages of WIDTH-bit payload, each with its own valid bit.
- Uses a valid/ready handshake on both sides. Bubbles collapse, so an empty stage absorbs data even while downstream is stalled.
- Sits between processor pipeline sections, or between a core and shared resources, where fixed-latency global stalls are too coarse.

Parameters:
- WIDTH, 32: payload width in bits (>=1).
- DEPTH, 2: number of register stages (>=1).
- ZERO_BUBBLES, 1: when 1, a stage's data register is cleared to 0 whenever that stage becomes invalid (reset, flush, or drain without refill). When 0, data of invalid stages is don't-care.

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- flush, input, 1: discard all contents at the next edge.
- in_valid, input, 1: upstream presents in_data.
- in_data, input, WIDTH: upstream payload.
- in_ready, output, 1: chain accepts in_data this cycle.
- out_valid, output, 1: last stage holds valid data.
- out_data, output, WIDTH: last-stage payload.
- out_ready, input, 1: downstream consumes out_data this cycle.
- count, output, $clog2(DEPTH+1) (min 1): number of valid stages.
- empty, output, 1: count==0.
- full, output, 1: count==DEPTH.

Behaviour:
- Stage indexing: stage 0 is input side, stage DEPTH-1 is output side.
- out_valid/out_data come directly from stage DEPTH-1 registers; no combinational path from in_* to out_*.
- Advance enable (combinational ready chain):
  - adv[DEPTH-1] = out_ready | !valid[DEPTH-1].
  - adv[i] = adv[i+1] | !valid[i], for i<DEPTH-1.
  - in_ready = adv[0] & !flush.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Per-edge update, when not Reset and not flush:
  - Stage i with adv[i]=1 loads from stage i-1, or from the input for i=0.
  - valid[i] takes the source's valid; for stage 0 the source valid is in_valid & in_ready.
  - Stage i with adv[i]=0 holds data and valid.
- Bubble collapse: a stalled downstream (out_ready=0) still lets data move into empty stages behind it. A full chain accepts new input in the same cycle the output is consumed.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- Latency: data accepted at edge N is visible on out_* after edge N+DEPTH-1 (immediately after acceptance when DEPTH=1) if the chain is empty and unstalled.
- flush (priority over normal update, below Reset):
  - All valid bits clear at the next edge.
  - Data clears to 0 if ZERO_BUBBLES=1.
  - in_ready=0 during flush, so no input is accepted.
  - An output consumed in the flush cycle counts as consumed.
- Reset: all valid=0, all data=0 (regardless of ZERO_BUBBLES), count=0, empty=1, full=0, out_valid=0, out_data=0. Reset asserted mid-stream drops all contents at that edge.
- count/empty/full:
  - count is registered and updated with the stage valids.
  - count increments on accept only, decrements on consume only, is unchanged on both or neither, and is forced to 0 on flush/Reset.
  - count must always equal the popcount of the valid bits.
- Boundaries:
  - full & out_ready=0: in_ready=0 and in_data is ignored.
  - full & out_ready=1: simultaneous accept and consume; count stays DEPTH.
  - empty & out_ready=1: out_valid=0; nothing is consumed.
- in_data sampled while in_ready=0 must not alter any register.
- DEPTH=1 degenerates to a single register with pass-through ready (in_ready = out_ready | !valid).

Test Plan:
1. Reset/latency (WIDTH=8, DEPTH=3): Reset 2 cycles, then in_valid=1, in_data=0xA5 for one cycle, out_ready=1 -> out_valid=1, out_data=0xA5 exactly 2 edges after acceptance; count goes 1,1,1 then 0 after consume. Before that, out_data=0x00 and empty=1.
2. Streaming: in_data 0x01..0x10 back-to-back with out_ready=1 -> in_ready stays 1; outputs 0x01..0x10 in order, one per cycle, no gaps or duplicates.
3. Backpressure and collapse: out_ready=0, feed 0x11,0x22,0x33,0x44 -> first three accepted, full=1, count=3, in_ready=0, 0x44 held upstream. Raise out_ready -> 0x44 accepted in the same cycle 0x11 is consumed; count stays 3.
4. Bubble collapse: stage 2 valid with out_ready=0, stage 1 empty, stage 0 holds 0x5A -> 0x5A moves to stage 1 next edge; in_ready=1.
5. Flush: chain holding 3 items, assert flush with in_valid=1, in_data=0x77 -> next edge count=0, out_valid=0, out_data=0 (ZERO_BUBBLES=1); 0x77 is never output.
6. Mid-stream Reset, with random in_valid/out_ready over 1000 cycles before and after -> scoreboard shows in-order, lossless delivery, count==popcount(valid) every cycle, and everything in flight at the Reset edge discarded.

Source files
------------

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_chain
// Purpose  : Elastic register chain of DEPTH stages carrying WIDTH-bit
//            payloads with per-stage valid bits and a valid/ready handshake
//            on both ends. Empty stages absorb data even while the output is
//            stalled, so bubbles collapse toward the output.
// Ports    : Clk        - clock, all state changes on the rising edge
//            Reset      - synchronous active-high reset, clears everything
//            flush      - discard all contents at the next edge
//            in_valid   - upstream presents in_data
//            in_data    - upstream payload
//            in_ready   - chain accepts in_data this cycle
//            out_valid  - last stage holds valid data
//            out_data   - last-stage payload
//            out_ready  - downstream consumes out_data this cycle
//            count      - number of valid stages (registered)
//            empty      - count == 0
//            full       - count == DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module pipe_chain #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int ZERO_BUBBLES = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    logic [DEPTH-1:0]   w_adv;
    logic               w_accept;
    logic               w_consume;

    // A stage may advance when the output is being drained or when any
    // stage at or beyond it is empty; this is the ready chain unrolled
    // from the output side so each bit is a simple OR of a running term.
    always_comb begin
        logic w_hole;
        w_adv  = '0;
        w_hole = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_hole   = w_hole | ~r_valid[i];
            w_adv[i] = out_ready | w_hole;
        end
    end

    assign in_ready  = w_adv[0] & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_valid[DEPTH-1] & out_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
            if (ZERO_BUBBLES != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= '0;
                end
            end
        end else begin
            // Stage 0 takes the input side; data only moves when a real
            // transfer happens, so in_data seen while not ready is ignored.
            if (w_adv[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= in_data;
                end else if (ZERO_BUBBLES != 0) begin
                    r_data[0] <= '0;
                end
            end

            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end else if (ZERO_BUBBLES != 0) begin
                        r_data[i] <= '0;
                    end
                end
            end

            // Internal shifts preserve the number of items; only the
            // boundary transfers change the occupancy.
            if (w_accept && !w_consume) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_accept && w_consume) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH_CNT);

endmodule
`default_nettype wire
